// File: rtl/pc_merge_pkg.sv
// Shared types, default widths and the round-robin grant function for the PC-word merge.
// Used by pc_word_route_merge (stats counters enabled with `define MERGE_STATS_EN).
package pc_merge_pkg;

  localparam int NIN_DEF    = 4;
  localparam int NCODE_DEF  = 8;
  localparam int NPAY_DEF   = 24;
  localparam int NROUTE_DEF = 10;
  localparam int NCNT_DEF   = 16;
  localparam int NMAX       = 16;

  typedef struct packed {
    logic [NCODE_DEF-1:0] code;
    logic [NPAY_DEF-1:0]  payload;
  } pc_word_t;

  typedef struct packed {
    logic [NCODE_DEF-1:0]  code;
    logic [NPAY_DEF-1:0]   payload;
    logic [NROUTE_DEF-1:0] route;
  } routed_pc_word_t;

  // One-hot grant for the first requester after ptr, scanning modulo n.
  function automatic logic [NMAX-1:0] rr_next(input logic [3:0] ptr,
                                               input logic [NMAX-1:0] req,
                                               input int n);
    logic [NMAX-1:0] g;
    logic            found;
    int              idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= NMAX; k++) begin
      if (k <= n) begin
        idx = (int'(ptr) + k) % n;
        if (!found && req[idx]) begin
          g[idx] = 1'b1;
          found  = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/pc_word_route_merge_rr_arbiter.sv
// Round-robin arbiter owning the priority pointer; the pointer moves to the
// granted index only when the consumer advances.
module rr_arbiter
  import pc_merge_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0]   r_ptr;
  logic [NMAX-1:0] w_req_ext;
  logic [NMAX-1:0] w_grant_full;
  logic            w_unused_hi;

  always_comb begin
    w_req_ext        = '0;
    w_req_ext[N-1:0] = req;
  end

  assign w_grant_full = rr_next(4'(r_ptr), w_req_ext, N);
  assign grant        = w_grant_full[N-1:0];
  assign w_unused_hi  = ^w_grant_full;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = IW'(i);
    end
  end

  // Reset pointer to the last index so input 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= IW'(N - 1);
    end else if (advance && (|req)) begin
      r_ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/pc_word_route_merge.sv
// N-way round-robin merge of v/a PC-word channels into one routed, registered output.
// Optional per-input transfer counters are built when `define MERGE_STATS_EN is set.
module pc_word_route_merge
  import pc_merge_pkg::*;
#(
  parameter int NIN    = NIN_DEF,
  parameter int NCODE  = NCODE_DEF,
  parameter int NPAY   = NPAY_DEF,
  parameter int NROUTE = NROUTE_DEF,
  parameter int NCNT   = NCNT_DEF,
  localparam int IW    = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NIN*NCODE-1:0]  in_code,
  input  logic [NIN*NPAY-1:0]   in_payload,
  input  logic [NIN-1:0]        in_v,
  output logic [NIN-1:0]        in_a,
  output logic [NCODE-1:0]      out_code,
  output logic [NPAY-1:0]       out_payload,
  output logic [NROUTE-1:0]     out_route,
  output logic                  out_v,
  input  logic                  out_a,
  input  logic [NIN-1:0]        conf_en,
  input  logic [NIN*NROUTE-1:0] conf_route,
  input  logic                  stat_clear,
  output logic [NIN*NCNT-1:0]   stat_count
);

  logic              r_out_v;
  logic [NCODE-1:0]  r_code;
  logic [NPAY-1:0]   r_payload;
  logic [NROUTE-1:0] r_route;

  logic              w_load;
  logic              w_advance;
  logic [NIN-1:0]    w_req;
  logic [NIN-1:0]    w_grant;
  logic [IW-1:0]     w_idx;

  assign w_load    = !r_out_v || out_a;
  assign w_advance = w_load && !reset;
  assign w_req     = in_v & conf_en;

  rr_arbiter #(.N(NIN)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (w_req),
    .advance   (w_advance),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  // Ack is suppressed during reset so no producer sees a word taken that is then dropped.
  assign in_a = w_advance ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_v   <= 1'b0;
      r_code    <= '0;
      r_payload <= '0;
      r_route   <= '0;
    end else if (w_load) begin
      if (|w_grant) begin
        r_out_v   <= 1'b1;
        r_code    <= in_code[w_idx*NCODE +: NCODE];
        r_payload <= in_payload[w_idx*NPAY +: NPAY];
        r_route   <= conf_route[w_idx*NROUTE +: NROUTE];
      end else begin
        r_out_v   <= 1'b0;
      end
    end
  end

  assign out_v       = r_out_v;
  assign out_code    = r_code;
  assign out_payload = r_payload;
  assign out_route   = r_route;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(in_a) && ((in_a & ~in_v) == '0))
        else $error("in_a not one-hot or acked without valid: %b / %b", in_a, in_v);
    end
  end

`ifdef MERGE_STATS_EN
  logic [NCNT-1:0] r_cnt [NIN];

  for (genvar i = 0; i < NIN; i++) begin : g_cnt
    // Clear wins over increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
      if (reset || stat_clear) begin
        r_cnt[i] <= '0;
      end else if (in_v[i] && in_a[i] && (r_cnt[i] != '1)) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
    assign stat_count[i*NCNT +: NCNT] = r_cnt[i];
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = stat_clear;
  assign stat_count   = '0;
`endif

endmodule

// File: tb/tb_pc_word_route_merge.sv
// Directed bench for pc_word_route_merge (NIN=4, NCNT=4); counter checks depend on MERGE_STATS_EN.
module tb_pc_word_route_merge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_code;
  logic [95:0] in_payload;
  logic [3:0]  in_v;
  logic [3:0]  in_a;
  logic [7:0]  out_code;
  logic [23:0] out_payload;
  logic [9:0]  out_route;
  logic        out_v;
  logic        out_a;
  logic [3:0]  conf_en;
  logic [39:0] conf_route;
  logic        stat_clear;
  logic [15:0] stat_count;

  int n_checks = 0;
  int n_err    = 0;

  logic [9:0] rt [4];
  logic [3:0] cnt1;

  always #5 clk = ~clk;

  pc_word_route_merge #(.NIN(4), .NCODE(8), .NPAY(24), .NROUTE(10), .NCNT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_code    (in_code),
    .in_payload (in_payload),
    .in_v       (in_v),
    .in_a       (in_a),
    .out_code   (out_code),
    .out_payload(out_payload),
    .out_route  (out_route),
    .out_v      (out_v),
    .out_a      (out_a),
    .conf_en    (conf_en),
    .conf_route (conf_route),
    .stat_clear (stat_clear),
    .stat_count (stat_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rt[0] = 10'h100; rt[1] = 10'h101; rt[2] = 10'h155; rt[3] = 10'h103;
    reset      = 1'b1;
    in_code    = {8'h13, 8'h3A, 8'h11, 8'h10};
    in_payload = {24'h001003, 24'hABCDEF, 24'h001001, 24'h001000};
    in_v       = 4'hF;
    out_a      = 1'b1;
    conf_en    = 4'hF;
    conf_route = {rt[3], rt[2], rt[1], rt[0]};
    stat_clear = 1'b0;
    step(); step();
    #1;
    chk("rst_out_v", 64'(out_v), 64'd0);
    chk("rst_out_data", 64'({out_code, out_payload, out_route}), 64'd0);
    chk("rst_in_a", 64'(in_a), 64'd0);

    // 1: single word on input 2
    reset = 1'b0;
    in_v  = 4'b0100;
    #1;
    chk("t1_in_a", 64'(in_a), 64'h4);
    step();
    in_v = 4'b0000;
    #1;
    chk("t1_out_v", 64'(out_v), 64'd1);
    chk("t1_word", 64'({out_code, out_payload, out_route}), 64'({8'h3A, 24'hABCDEF, 10'h155}));
    chk("t1_in_a_once", 64'(in_a), 64'd0);
    step();
    chk("t1_drain", 64'(out_v), 64'd0);

    // 2: full-rate round robin from a fresh pointer
    reset = 1'b1;
    step();
    reset   = 1'b0;
    in_code = {8'h13, 8'h12, 8'h11, 8'h10};
    in_v    = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t2_in_a", 64'(in_a), 64'(4'b0001 << (k % 4)));
      step();
      chk("t2_out_v", 64'(out_v), 64'd1);
      chk("t2_code", 64'(out_code), 64'(8'h10 + 8'(k % 4)));
      chk("t2_route", 64'(out_route), 64'(rt[k % 4]));
    end

    // 3: backpressure holds word 3
    out_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_in_a", 64'(in_a), 64'd0);
      chk("t3_hold", 64'({out_v, out_code, out_payload, out_route}),
          64'({1'b1, 8'h13, 24'h001003, 10'h103}));
      step();
    end
    out_a = 1'b1;
    #1;
    chk("t3_resume_a", 64'(in_a), 64'h1);
    step();
    chk("t3_resume_code", 64'(out_code), 64'h10);

    // 4: only inputs 1 and 3 enabled
    conf_en = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_in_a", 64'(in_a), (k % 2 == 0) ? 64'h2 : 64'h8);
      step();
      chk("t4_code", 64'(out_code), (k % 2 == 0) ? 64'h11 : 64'h13);
    end

    // 5: reset while output is stalled
    conf_en = 4'hF;
    out_a   = 1'b0;
    reset   = 1'b1;
    #1;
    chk("t5_in_a_rst", 64'(in_a), 64'd0);
    step();
    chk("t5_out_v", 64'(out_v), 64'd0);
    chk("t5_in_a", 64'(in_a), 64'd0);
    reset = 1'b0;
    out_a = 1'b1;
    #1;
    chk("t5_first_prio", 64'(in_a), 64'h1);
    step();
    chk("t5_code", 64'(out_code), 64'h10);

    // 6: statistics counters on input 1
    in_v       = 4'b0000;
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    chk("t6_clear", 64'(stat_count), 64'd0);
    in_v = 4'b0010;
    for (int k = 0; k < 14; k++) step();
    cnt1 = stat_count[7:4];
`ifdef MERGE_STATS_EN
    chk("t6_cnt14", 64'(cnt1), 64'hE);
`else
    chk("t6_cnt14_off", 64'(stat_count), 64'd0);
`endif
    for (int k = 0; k < 6; k++) step();
    cnt1 = stat_count[7:4];
`ifdef MERGE_STATS_EN
    chk("t6_sat", 64'(cnt1), 64'hF);
    chk("t6_others", 64'({stat_count[15:8], stat_count[3:0]}), 64'd0);
`else
    chk("t6_sat_off", 64'(stat_count), 64'd0);
`endif
    stat_clear = 1'b1;
    #1;
    chk("t6_xfer_during_clr", 64'(in_a), 64'h2);
    step();
    stat_clear = 1'b0;
    in_v       = 4'b0000;
    chk("t6_clr_prio", 64'(stat_count), 64'd0);
    in_v = 4'b0010;
    step();
    in_v = 4'b0000;
    cnt1 = stat_count[7:4];
`ifdef MERGE_STATS_EN
    chk("t6_after_clr", 64'(cnt1), 64'h1);
`else
    chk("t6_after_clr_off", 64'(stat_count), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
